// File: rtl/qos_flow_ctrl.sv
// Main-state and flow controller for the QoS datapath: life-cycle FSM, strict-priority
// VC0/VC1 arbitration into D0/D1 with almost-full backpressure and a one-word pipeline.
module qos_flow_ctrl #(
  parameter int unsigned BW   = 6,
  parameter int unsigned LEN4 = 4
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            init,
  input  logic [LEN4-1:0] umbral_bajo_in,
  input  logic [LEN4-1:0] umbral_alto_in,
  output logic [LEN4-1:0] umbral_bajo,
  output logic [LEN4-1:0] umbral_alto,
  input  logic            VC0_empty,
  input  logic            VC1_empty,
  input  logic            D0_empty,
  input  logic            D1_empty,
  input  logic            D0_full,
  input  logic            D1_full,
  input  logic            D0_almost_full,
  input  logic            D1_almost_full,
  input  logic            fifo_error,
  input  logic [BW-1:0]   VC0_data,
  input  logic [BW-1:0]   VC1_data,
  output logic            VC0_rd,
  output logic            VC1_rd,
  output logic            D0_wr,
  output logic            D1_wr,
  output logic [BW-1:0]   D_data_out,
  output logic [4:0]      state,
  output logic            idle_out,
  output logic            error_out
);

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;

  state_t          state_q, state_d;
  logic            valid_q, src_q;
  logic [LEN4-1:0] bajo_q, alto_q;
  logic            stall_c, any_data_c, push_en_c, err_c;
  logic [BW-1:0]   push_word_c;

  assign stall_c    = D0_almost_full | D1_almost_full;
  assign any_data_c = ~(VC0_empty & VC1_empty & D0_empty & D1_empty);

  // Push side: the word popped last cycle, dropped once the FSM is in ERROR
  assign push_en_c   = valid_q && (state_q != S_ERROR);
  assign push_word_c = src_q ? VC1_data : VC0_data;
  assign D_data_out  = push_en_c ? push_word_c : '0;
  assign D0_wr       = push_en_c & ~push_word_c[BW-1];
  assign D1_wr       = push_en_c & push_word_c[BW-1];
  assign err_c       = fifo_error | (D0_wr & D0_full) | (D1_wr & D1_full);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  // Next state plus pop arbitration; VC0 strictly ahead of VC1
  always_comb begin
    state_d = state_q;
    VC0_rd  = 1'b0;
    VC1_rd  = 1'b0;
    if (state_q == S_ACTIVE && !stall_c) begin
      if (!VC0_empty)      VC0_rd = 1'b1;
      else if (!VC1_empty) VC1_rd = 1'b1;
    end
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   if (!init) state_d = S_IDLE;
      S_IDLE: begin
        if (init)            state_d = S_INIT;
        else if (any_data_c) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (init)                         state_d = S_INIT;
        else if (!any_data_c && !valid_q) state_d = S_IDLE;
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase
    if (state_q != S_RESET && err_c) state_d = S_ERROR;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_q <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      valid_q <= VC0_rd | VC1_rd;
      src_q   <= VC1_rd;
    end
  end

  // Thresholds track the inputs only while configuring
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bajo_q <= '0;
      alto_q <= '0;
    end else if (state_q == S_INIT) begin
      bajo_q <= umbral_bajo_in;
      alto_q <= umbral_alto_in;
    end
  end

  assign umbral_bajo = bajo_q;
  assign umbral_alto = alto_q;
  assign state       = state_q;
  assign idle_out    = (state_q == S_IDLE);
  assign error_out   = (state_q == S_ERROR);

endmodule

// File: tb/tb_qos_flow_ctrl.sv
// Directed bench for qos_flow_ctrl: a cycle table for config/priority/backpressure,
// then hand sequences for mid-flight init, overflow error and fifo_error.
module tb_qos_flow_ctrl;

  localparam logic [4:0] RST = 5'b00001;
  localparam logic [4:0] INI = 5'b00010;
  localparam logic [4:0] IDL = 5'b00100;
  localparam logic [4:0] ACT = 5'b01000;
  localparam logic [4:0] ERR = 5'b10000;

  logic       clk = 1'b0;
  logic       reset_L, init;
  logic [3:0] umbral_bajo_in, umbral_alto_in, umbral_bajo, umbral_alto;
  logic       VC0_empty, VC1_empty, D0_empty, D1_empty;
  logic       D0_full, D1_full, D0_almost_full, D1_almost_full, fifo_error;
  logic [5:0] VC0_data, VC1_data, D_data_out;
  logic       VC0_rd, VC1_rd, D0_wr, D1_wr, idle_out, error_out;
  logic [4:0] state;

  int checks = 0;
  int errors = 0;

  qos_flow_ctrl #(.BW(6), .LEN4(4)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_bajo_in(umbral_bajo_in), .umbral_alto_in(umbral_alto_in),
    .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
    .VC0_empty(VC0_empty), .VC1_empty(VC1_empty), .D0_empty(D0_empty), .D1_empty(D1_empty),
    .D0_full(D0_full), .D1_full(D1_full),
    .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
    .fifo_error(fifo_error), .VC0_data(VC0_data), .VC1_data(VC1_data),
    .VC0_rd(VC0_rd), .VC1_rd(VC1_rd), .D0_wr(D0_wr), .D1_wr(D1_wr),
    .D_data_out(D_data_out), .state(state), .idle_out(idle_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, init, e0, e1, de0, de1, af0, af1;
    logic [5:0] d0, d1;
    logic [3:0] bi, ai;
    logic [4:0] st;
    logic       rd0, rd1, wr0, wr1;
    logic [5:0] dout;
    logic [3:0] ub, ua;
  } vec_t;

  function automatic vec_t v(input logic rst, init, e0, e1, de0, de1, af0, af1,
                             input logic [5:0] d0, d1, input logic [3:0] bi, ai,
                             input logic [4:0] st, input logic rd0, rd1, wr0, wr1,
                             input logic [5:0] dout, input logic [3:0] ub, ua);
    vec_t r;
    r.rst = rst; r.init = init; r.e0 = e0; r.e1 = e1; r.de0 = de0; r.de1 = de1;
    r.af0 = af0; r.af1 = af1; r.d0 = d0; r.d1 = d1; r.bi = bi; r.ai = ai;
    r.st = st; r.rd0 = rd0; r.rd1 = rd1; r.wr0 = wr0; r.wr1 = wr1;
    r.dout = dout; r.ub = ub; r.ua = ua;
    return r;
  endfunction

  task automatic chk(input string tag, input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, nm, act, exp);
    end
  endtask

  // Waits to mid-cycle, then compares every output against the expectation
  task automatic expect_out(input string tag, input logic [4:0] st, input logic rd0, rd1, wr0, wr1,
                            input logic [5:0] dout, input logic [3:0] ub, ua);
    #4;
    chk(tag, "state", 8'(state), 8'(st));
    chk(tag, "VC0_rd", 8'(VC0_rd), 8'(rd0));
    chk(tag, "VC1_rd", 8'(VC1_rd), 8'(rd1));
    chk(tag, "D0_wr", 8'(D0_wr), 8'(wr0));
    chk(tag, "D1_wr", 8'(D1_wr), 8'(wr1));
    chk(tag, "D_data_out", 8'(D_data_out), 8'(dout));
    chk(tag, "umbral_bajo", 8'(umbral_bajo), 8'(ub));
    chk(tag, "umbral_alto", 8'(umbral_alto), 8'(ua));
    chk(tag, "idle_out", 8'(idle_out), 8'(st == IDL));
    chk(tag, "error_out", 8'(error_out), 8'(st == ERR));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    // rst init e0 e1 de0 de1 af0 af1 d0 d1 bi ai | st rd0 rd1 wr0 wr1 dout ub ua
    tbl.push_back(v(0,1,1,1,1,1,0,0,6'h00,6'h00,4'd1,4'd3, RST,0,0,0,0,6'h00,4'd0,4'd0));
    tbl.push_back(v(1,1,1,1,1,1,0,0,6'h00,6'h00,4'd1,4'd3, RST,0,0,0,0,6'h00,4'd0,4'd0));
    tbl.push_back(v(1,1,1,1,1,1,0,0,6'h00,6'h00,4'd1,4'd3, INI,0,0,0,0,6'h00,4'd0,4'd0));
    tbl.push_back(v(1,1,1,1,1,1,0,0,6'h00,6'h00,4'd1,4'd3, INI,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,1,1,1,1,0,0,6'h00,6'h00,4'd1,4'd3, INI,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,1,1,1,1,0,0,6'h00,6'h00,4'd5,4'd8, IDL,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,1,1,1,1,0,0,6'h00,6'h00,4'd5,4'd8, IDL,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,0,0,1,1,0,0,6'h05,6'h30,4'd5,4'd8, IDL,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,0,0,1,1,0,0,6'h05,6'h30,4'd5,4'd8, ACT,1,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,0,0,1,1,0,0,6'h05,6'h30,4'd5,4'd8, ACT,1,0,1,0,6'h05,4'd1,4'd3));
    tbl.push_back(v(1,0,1,0,0,1,0,0,6'h25,6'h30,4'd5,4'd8, ACT,0,1,0,1,6'h25,4'd1,4'd3));
    tbl.push_back(v(1,0,1,1,1,1,0,0,6'h25,6'h30,4'd5,4'd8, ACT,0,0,0,1,6'h30,4'd1,4'd3));
    tbl.push_back(v(1,0,1,1,1,1,0,0,6'h25,6'h30,4'd5,4'd8, ACT,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,1,1,1,1,0,0,6'h25,6'h30,4'd5,4'd8, IDL,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,0,1,1,1,0,1,6'h11,6'h00,4'd5,4'd8, IDL,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,0,1,1,1,1,0,6'h11,6'h00,4'd5,4'd8, ACT,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,0,1,1,1,0,1,6'h11,6'h00,4'd5,4'd8, ACT,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,0,1,1,1,0,0,6'h11,6'h00,4'd5,4'd8, ACT,1,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,1,1,1,1,0,0,6'h11,6'h00,4'd5,4'd8, ACT,0,0,1,0,6'h11,4'd1,4'd3));
    tbl.push_back(v(1,0,1,1,1,1,0,0,6'h11,6'h00,4'd5,4'd8, ACT,0,0,0,0,6'h00,4'd1,4'd3));
    tbl.push_back(v(1,0,1,1,1,1,0,0,6'h11,6'h00,4'd5,4'd8, IDL,0,0,0,0,6'h00,4'd1,4'd3));

    reset_L = 1'b1; init = 1'b1;
    umbral_bajo_in = 4'd1; umbral_alto_in = 4'd3;
    VC0_empty = 1'b1; VC1_empty = 1'b1; D0_empty = 1'b1; D1_empty = 1'b1;
    D0_full = 1'b0; D1_full = 1'b0; D0_almost_full = 1'b0; D1_almost_full = 1'b0;
    fifo_error = 1'b0; VC0_data = '0; VC1_data = '0;
    #1 reset_L = 1'b0;
    tick();

    foreach (tbl[i]) begin
      reset_L = tbl[i].rst; init = tbl[i].init;
      VC0_empty = tbl[i].e0; VC1_empty = tbl[i].e1;
      D0_empty = tbl[i].de0; D1_empty = tbl[i].de1;
      D0_almost_full = tbl[i].af0; D1_almost_full = tbl[i].af1;
      VC0_data = tbl[i].d0; VC1_data = tbl[i].d1;
      umbral_bajo_in = tbl[i].bi; umbral_alto_in = tbl[i].ai;
      expect_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].rd0, tbl[i].rd1, tbl[i].wr0,
                 tbl[i].wr1, tbl[i].dout, tbl[i].ub, tbl[i].ua);
      tick();
    end

    // init raised while a word is in flight: word still lands, no further pops
    VC0_empty = 1'b0; VC0_data = 6'h2A;
    expect_out("mid_a1", IDL, 0, 0, 0, 0, 6'h00, 4'd1, 4'd3); tick();
    init = 1'b1; umbral_bajo_in = 4'd2; umbral_alto_in = 4'd6;
    expect_out("mid_a2", ACT, 1, 0, 0, 0, 6'h00, 4'd1, 4'd3); tick();
    expect_out("mid_a3", INI, 0, 0, 0, 1, 6'h2A, 4'd1, 4'd3); tick();
    init = 1'b0;
    expect_out("mid_a4", INI, 0, 0, 0, 0, 6'h00, 4'd2, 4'd6); tick();
    VC0_empty = 1'b1;
    expect_out("mid_a5", IDL, 0, 0, 0, 0, 6'h00, 4'd2, 4'd6); tick();

    // push into a full D0 -> sticky ERROR until reset
    VC0_empty = 1'b0; VC0_data = 6'h0A;
    expect_out("ovf_b1", IDL, 0, 0, 0, 0, 6'h00, 4'd2, 4'd6); tick();
    expect_out("ovf_b2", ACT, 1, 0, 0, 0, 6'h00, 4'd2, 4'd6); tick();
    VC0_empty = 1'b1; D0_full = 1'b1;
    expect_out("ovf_b3", ACT, 0, 0, 1, 0, 6'h0A, 4'd2, 4'd6); tick();
    D0_full = 1'b0;
    expect_out("ovf_b4", ERR, 0, 0, 0, 0, 6'h00, 4'd2, 4'd6); tick();
    for (int i = 0; i < 4; i++) begin
      init = (i % 2 == 0); VC0_empty = 1'b0;
      expect_out($sformatf("ovf_hold%0d", i), ERR, 0, 0, 0, 0, 6'h00, 4'd2, 4'd6);
      tick();
    end
    reset_L = 1'b0; init = 1'b0; VC0_empty = 1'b1;
    expect_out("ovf_rst", RST, 0, 0, 0, 0, 6'h00, 4'd0, 4'd0); tick();
    reset_L = 1'b1;
    expect_out("ovf_rel", RST, 0, 0, 0, 0, 6'h00, 4'd0, 4'd0); tick();
    expect_out("ovf_init", INI, 0, 0, 0, 0, 6'h00, 4'd0, 4'd0); tick();
    expect_out("ovf_idle", IDL, 0, 0, 0, 0, 6'h00, 4'd2, 4'd6); tick();

    // single-cycle fifo_error pulse from IDLE
    fifo_error = 1'b1;
    expect_out("ferr_c1", IDL, 0, 0, 0, 0, 6'h00, 4'd2, 4'd6); tick();
    fifo_error = 1'b0;
    expect_out("ferr_c2", ERR, 0, 0, 0, 0, 6'h00, 4'd2, 4'd6); tick();
    expect_out("ferr_c3", ERR, 0, 0, 0, 0, 6'h00, 4'd2, 4'd6); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
